// File: rtl/y86_regfile_pkg.sv
// Shared Y86-64 encodings: register IDs, instruction codes and register-file sizing.
// Every file that decodes a register or instruction number imports this package.
package y86_regfile_pkg;

    localparam int REG_COUNT = 15;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] RR8   = 4'h8;
    localparam logic [3:0] RR9   = 4'h9;
    localparam logic [3:0] RR10  = 4'hA;
    localparam logic [3:0] RR11  = 4'hB;
    localparam logic [3:0] RR12  = 4'hC;
    localparam logic [3:0] RR13  = 4'hD;
    localparam logic [3:0] RR14  = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    function automatic logic is_live(input logic [3:0] addr);
        return addr != RNONE;
    endfunction

endpackage

// File: rtl/y86_regfile_read_port.sv
// One combinational register-file read port: RNONE reads as zero, and with BYPASS set
// the write-back data being committed this cycle is forwarded (valM beats valE).
module y86_regfile_read_port
    import y86_regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter bit BYPASS = 1'b0
) (
    input  logic [3:0]        i_addr,
    input  logic [DATA_W-1:0] i_regs [REG_COUNT],
    input  logic              i_wen,
    input  logic [3:0]        i_dstE,
    input  logic [DATA_W-1:0] i_valE,
    input  logic [3:0]        i_dstM,
    input  logic [DATA_W-1:0] i_valM,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit_e;
    logic w_hit_m;

    assign w_hit_e = BYPASS && i_wen && is_live(i_addr) && (i_dstE == i_addr);
    assign w_hit_m = BYPASS && i_wen && is_live(i_addr) && (i_dstM == i_addr);

    always_comb begin
        o_data = '0;
        if (w_hit_m) begin
            o_data = i_valM;
        end else if (w_hit_e) begin
            o_data = i_valE;
        end else if (is_live(i_addr)) begin
            o_data = i_regs[i_addr];
        end
    end

endmodule

// File: rtl/y86_regfile.sv
// Y86-64 SEQ register file: fifteen registers, two read ports plus a debug port,
// dual write-back (valM wins on conflict) and a saturating committed-write counter.
module y86_regfile
    import y86_regfile_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter bit                BYPASS   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              wen,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_cnt
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [31:0]       r_wr_cnt;
    logic              w_wr_e;
    logic              w_wr_m;
    logic [1:0]        w_n_writes;

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] n);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'd0, n};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign w_wr_e = wen && is_live(dstE);
    assign w_wr_m = wen && is_live(dstM);

    // A dual write to the same register touches only one register.
    always_comb begin
        w_n_writes = 2'd0;
        if (w_wr_e && w_wr_m && (dstE == dstM)) begin
            w_n_writes = 2'd1;
        end else begin
            w_n_writes = {1'b0, w_wr_e} + {1'b0, w_wr_m};
        end
    end

    // The valM write comes last so it overrides valE when both target one register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= (4'(i) == RRSP) ? RSP_INIT : '0;
            end
            r_wr_cnt <= '0;
        end else begin
            if (w_wr_e) begin
                r_regs[dstE] <= valE;
            end
            if (w_wr_m) begin
                r_regs[dstM] <= valM;
            end
            r_wr_cnt <= sat_add(r_wr_cnt, w_n_writes);
        end
    end

    assign wr_cnt = r_wr_cnt;

    y86_regfile_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port_a (
        .i_addr (srcA),
        .i_regs (r_regs),
        .i_wen  (wen),
        .i_dstE (dstE),
        .i_valE (valE),
        .i_dstM (dstM),
        .i_valM (valM),
        .o_data (valA)
    );

    y86_regfile_read_port #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_port_b (
        .i_addr (srcB),
        .i_regs (r_regs),
        .i_wen  (wen),
        .i_dstE (dstE),
        .i_valE (valE),
        .i_dstM (dstM),
        .i_valM (valM),
        .o_data (valB)
    );

    y86_regfile_read_port #(.DATA_W(DATA_W), .BYPASS(1'b0)) u_port_dbg (
        .i_addr (dbg_addr),
        .i_regs (r_regs),
        .i_wen  (wen),
        .i_dstE (dstE),
        .i_valE (valE),
        .i_dstM (dstM),
        .i_valM (valM),
        .o_data (dbg_data)
    );

endmodule

// File: tb/tb_y86_regfile.sv
// Scoreboard bench for y86_regfile: one plain and one bypassing instance share stimulus,
// expectations come from an array model of the architectural registers.
module tb_y86_regfile;

    localparam logic [63:0] RSP_RST = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  srcA, srcB, dstE, dstM, dbg_addr;
    logic [63:0] valE, valM;
    logic        wen;
    logic [63:0] valA, valB, dbg_data, valA_b, valB_b, dbg_data_b;
    logic [31:0] wr_cnt, wr_cnt_b;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    y86_regfile #(.DATA_W(64), .RSP_INIT(RSP_RST), .BYPASS(1'b0)) u_dut (
        .clk(clk), .rst(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wen(wen),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_cnt(wr_cnt)
    );

    y86_regfile #(.DATA_W(64), .RSP_INIT(RSP_RST), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA_b), .valB(valB_b),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wen(wen),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .wr_cnt(wr_cnt_b)
    );

    // Reference model: architectural register contents and committed-write count.
    logic [63:0] model [15];
    logic [31:0] mcnt;

    typedef struct {
        string       tag;
        logic [63:0] a, b, dbg, a_byp, b_byp;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    function automatic logic [63:0] rd(input logic [3:0] a);
        if (a == 4'hF) return 64'd0;
        return model[a];
    endfunction

    function automatic logic [63:0] fwd(input logic [3:0] a);
        if (a == 4'hF) return 64'd0;
        if (wen && dstM == a) return valM;
        if (wen && dstE == a) return valE;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = (i == 4) ? RSP_RST : 64'd0;
        mcnt = 32'd0;
    endtask

    task automatic model_commit();
        logic [15:0] touched;
        longint      total;
        touched = 16'd0;
        if (!wen) return;
        if (dstE != 4'hF) begin model[dstE] = valE; touched[dstE] = 1'b1; end
        if (dstM != 4'hF) begin model[dstM] = valM; touched[dstM] = 1'b1; end
        total = longint'(mcnt) + longint'($countones(touched));
        mcnt = (total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(total);
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.a     = rd(srcA);
        e.b     = rd(srcB);
        e.dbg   = rd(dbg_addr);
        e.a_byp = fwd(srcA);
        e.b_byp = fwd(srcB);
        e.cnt   = mcnt;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational and settle between the driving posedge and this negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".valA"},       valA,               e.a);
            chk({e.tag, ".valB"},       valB,               e.b);
            chk({e.tag, ".dbg"},        dbg_data,           e.dbg);
            chk({e.tag, ".wr_cnt"},     {32'd0, wr_cnt},    {32'd0, e.cnt});
            chk({e.tag, ".byp.valA"},   valA_b,             e.a_byp);
            chk({e.tag, ".byp.valB"},   valB_b,             e.b_byp);
            chk({e.tag, ".byp.dbg"},    dbg_data_b,         e.dbg);
            chk({e.tag, ".byp.wr_cnt"}, {32'd0, wr_cnt_b},  {32'd0, e.cnt});
        end
    end

    task automatic step(input logic [3:0] sa, input logic [3:0] sb_a, input logic [3:0] de,
                        input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                        input logic w, input logic [3:0] da, input string tag);
        srcA = sa; srcB = sb_a; dstE = de; valE = ve; dstM = dm; valM = vm;
        wen = w; dbg_addr = da;
        push_exp(tag);
        @(posedge clk);
        if (rst_n) model_commit();
        #1;
    endtask

    function automatic logic [3:0] rand_dst();
        return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    endfunction

    initial begin
        rst_n = 1'b0;
        srcA = 4'h0; srcB = 4'h4; dstE = 4'hF; dstM = 4'hF;
        valE = '0; valM = '0; wen = 1'b0; dbg_addr = 4'h4;
        model_reset();
        #1;
        push_exp("rst_hold");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 16; a++)
            step(4'(a), 4'(15 - a), 4'hF, 64'd0, 4'hF, 64'd0, 1'b0, 4'(a), "rst_val");

        step(4'h0, 4'h0, 4'h2, 64'hDEAD_BEEF, 4'hF, 64'd0, 1'b1, 4'h2, "wr2");
        step(4'h2, 4'h4, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0, 4'h2, "rd2");

        step(4'h4, 4'h0, 4'h4, 64'h108, 4'h4, 64'h55, 1'b1, 4'h4, "popq");
        step(4'h4, 4'h2, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0, 4'h4, "popq_chk");

        step(4'h1, 4'h3, 4'h1, 64'hAAAA, 4'h3, 64'hBBBB, 1'b1, 4'h1, "wr13");
        step(4'h1, 4'h3, 4'h1, {$urandom, $urandom}, 4'h3, {$urandom, $urandom}, 1'b0, 4'h1, "wen0");
        step(4'h1, 4'h3, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0, 4'h3, "wen0_chk");

        step(4'h7, 4'h7, 4'h7, 64'h11, 4'hF, 64'd0, 1'b1, 4'h7, "byp7");
        step(4'h7, 4'h6, 4'h7, 64'h22, 4'h7, 64'h33, 1'b1, 4'h7, "byp_both");
        step(4'hF, 4'hF, 4'hF, 64'h44, 4'hF, 64'h66, 1'b1, 4'h7, "byp_none");
        step(4'h6, 4'h7, 4'h6, 64'h88, 4'h7, 64'h99, 1'b0, 4'h7, "byp_wen0");

        // Reset asserted mid-cycle with a write of reg5 pending.
        step(4'h0, 4'h5, 4'h5, 64'h5555, 4'h0, 64'h77, 1'b1, 4'h5, "pre_arst");
        srcA = 4'h0; srcB = 4'h1; dstE = 4'h5; valE = 64'h9999; dstM = 4'hF;
        wen = 1'b1; dbg_addr = 4'h5;
        #2;
        rst_n = 1'b0;
        model_reset();
        push_exp("arst");
        @(posedge clk); #1;
        push_exp("arst_hold");
        #2;
        wen = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(4'h5, 4'h4, 4'hF, 64'd0, 4'hF, 64'd0, 1'b0, 4'h5, "arst_after");

        for (int n = 0; n < 300; n++) begin
            logic [3:0] de, dm;
            de = rand_dst();
            dm = ($urandom_range(0, 5) == 0) ? de : rand_dst();
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), de, {$urandom, $urandom},
                 dm, {$urandom, $urandom}, ($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 15)), "rand");
        end

        wen = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/y86_regfile.md
Name: y86_regfile

Overview:
- Y86-64 SEQ register file. It sits directly downstream of decode.
- Takes srcA/srcB from decode and returns valA/valB to execute.
- Accepts the write-back pair (dstE/valE, dstM/valM) at the clock edge that ends the instruction.
- Fifteen program registers, encodings 0x0..0xE; 0xF is RNONE.

Parameters:
- DATA_W, 64, register width in bits.
- RSP_INIT, 64'h0, reset value of %rsp (encoding 0x4); every other register resets to 0.
- BYPASS, 0: 0 = reads return pre-edge contents; 1 = same-cycle write data is forwarded to the read ports.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- srcA  input  4  read address A from decode; 0xF = none.
- srcB  input  4  read address B from decode; 0xF = none.
- valA  output  DATA_W  read data A.
- valB  output  DATA_W  read data B.
- dstE  input  4  write address for the execute result; 0xF = none.
- valE  input  DATA_W  execute result.
- dstM  input  4  write address for the memory result; 0xF = none.
- valM  input  DATA_W  memory read result.
- wen  input  1  global write enable; driven low by control when stat != AOK or the core is stalled.
- dbg_addr  input  4  debug/testbench read address.
- dbg_data  output  DATA_W  debug read data; always combinational, never bypassed.
- wr_cnt  output  32  count of committed register writes (saturating), for bench/perf.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers go to 0, except reg[4] = RSP_INIT.
  - wr_cnt = 0.
  - outputs reflect the reset contents immediately.
- Reads are combinational:
  - valA = (srcA==RNONE) ? 0 : reg[srcA]; valB likewise.
  - dbg_data follows the same rule with dbg_addr.
- Writes happen on the rising edge of clk when rst is high and wen=1:
  - if dstE != RNONE: reg[dstE] <= valE.
  - if dstM != RNONE: reg[dstM] <= valM.
- Write conflict (dstE == dstM != RNONE): valM wins. This covers popq %rsp: the stack pointer ends up holding the popped value, not the incremented pointer.
- wen=0: no register changes and wr_cnt holds, regardless of dst values.
- wr_cnt:
  - increments by the number of distinct registers actually written that edge: 0, 1, or 2.
  - a conflicting dual write counts as 1.
  - saturates at 32'hFFFF_FFFF.
- BYPASS=1:
  - if wen=1 and srcX matches a live destination, valX is taken from the write data, not reg[srcX].
  - priority is valM over valE when both match.
  - RNONE never bypasses.
- Width: all values are DATA_W, no sign or extension logic. Addresses are the full 4 bits; 0xF is the only invalid encoding.
- Reset asserted in the middle of a cycle that has a write pending: reset dominates and the write is lost.
- Reset deasserted: the first write takes effect at the first rising edge with rst high.
- Latency:
  - read: 0 cycles (combinational).
  - write: visible on valA/valB/dbg_data right after the edge, or in the same cycle if BYPASS=1.

Decomposition:
- Encodings come from the shared defines header, with no local literals:
  - RNONE (4'hF), RRSP (4'h4), register encodings, and the Y86 icode constants.
- Add the new constant REG_COUNT (15) to that header.
- Natural sub-module: regfile_read_port (address decode, RNONE zeroing, optional bypass mux).
  - Instantiated three times: A, B, and debug; the debug instance has bypass disabled.
- Write logic and wr_cnt stay in the top level.

Test Plan:
- Reset with RSP_INIT=64'h100 -> dbg_data reads 0 for regs 0..3 and 5..14, 64'h100 for reg 4, and 0 for addr 0xF; wr_cnt=0.
- dstE=2, valE=64'hDEAD_BEEF, dstM=0xF, wen=1, one edge -> srcA=2 gives valA=64'hDEAD_BEEF; wr_cnt=1.
- dstE=4, valE=64'h108, dstM=4, valM=64'h55, wen=1 (popq %rsp) -> reg4=64'h55; wr_cnt increments by 1.
- dstE=1, dstM=3, wen=0, random data -> reg1 and reg3 unchanged; wr_cnt unchanged.
- BYPASS=1: srcA=7, dstE=7, valE=64'h11, same cycle -> valA=64'h11 before the edge; dbg_addr=7 still shows the old value.
- Assert rst low asynchronously mid-cycle with dstE=5 pending -> reg5 reads 0 immediately and stays 0 after the edge; the write is dropped.
